// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the RV12 memory-port arbiter: FSM states, port owner, counter width.
`timescale 1ns/1ps
package rv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/rv_mem_port_arb_if.sv
// Shared core-side memory port: the arbiter is the master, the bus interface the slave.
`timescale 1ns/1ps
interface rv_mem_port_arb_if #(
    parameter int unsigned XLEN = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN-1:0]   mem_adr_o;
    logic [XLEN-1:0]   mem_d_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic              mem_ack_i;
    logic [XLEN-1:0]   mem_q_i;

    modport master (
        output mem_req_o, mem_we_o, mem_adr_o, mem_d_o, mem_be_o,
        input  mem_ack_i, mem_q_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_adr_o, mem_d_o, mem_be_o,
        output mem_ack_i, mem_q_i
    );
endinterface

// File: rtl/rv_arb_starve_cnt.sv
// Saturating count of data grants made while fetch waits; hit when the limit is reached.
`timescale 1ns/1ps
module rv_arb_starve_cnt
    import rv_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [STARVE_CNT_W-1:0] MaxCnt = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == MaxCnt);

endmodule

// File: rtl/rv_mem_port_arb.sv
// Fetch/data arbiter for the single RV12 memory port, data has priority, one transaction at a time.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_MAX data grants made while it waited.
`timescale 1ns/1ps
module rv_mem_port_arb
    import rv_mem_arb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,

    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_adr_i,
    output logic                if_ack_o,
    output logic [XLEN-1:0]     if_q_o,

    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [XLEN-1:0]     dm_adr_i,
    input  logic [XLEN-1:0]     dm_d_i,
    input  logic [XLEN/8-1:0]   dm_be_i,
    output logic                dm_ack_o,
    output logic [XLEN-1:0]     dm_q_o,

    rv_mem_port_arb_if.master   mem,

    output logic                arb_owner_o
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
        $error("rv_mem_port_arb: STARVE_MAX must be in 1..15");
    end

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic [XLEN-1:0]   dat_q, dat_d;
    logic [XLEN/8-1:0] be_q, be_d;

    logic grant_if;
    logic grant_dm;
    logic starve_hit;

`ifdef ARB_STARVE_GUARD_EN
    rv_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .inc   (grant_dm && if_req_i),
        .clr   (grant_if),
        .hit   (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        req_d    = req_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        be_d     = be_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;

        case (state_q)
            IDLE: begin
                // fetch only overtakes a pending data request when the guard has tripped
                if (dm_req_i && !(if_req_i && starve_hit)) begin
                    grant_dm = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem.mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (grant_dm) begin
            state_d = BUSY_DM;
            owner_d = OWN_DM;
            req_d   = 1'b1;
            we_d    = dm_we_i;
            adr_d   = dm_adr_i;
            dat_d   = dm_d_i;
            be_d    = dm_be_i;
        end

        if (grant_if) begin
            state_d = BUSY_IF;
            owner_d = OWN_IF;
            req_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = if_adr_i;
            dat_d   = '0;
            be_d    = '1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            be_q    <= be_d;
        end
    end

    assign mem.mem_req_o = req_q;
    assign mem.mem_we_o  = we_q;
    assign mem.mem_adr_o = adr_q;
    assign mem.mem_d_o   = dat_q;
    assign mem.mem_be_o  = be_q;
    assign arb_owner_o   = owner_q;

    always_comb begin
        if_ack_o = (state_q == BUSY_IF) && mem.mem_ack_i;
        dm_ack_o = (state_q == BUSY_DM) && mem.mem_ack_i;
        if_q_o   = if_ack_o ? mem.mem_q_i : '0;
        dm_q_o   = dm_ack_o ? mem.mem_q_i : '0;
    end

endmodule

// File: tb/tb_rv_mem_port_arb.sv
// Scoreboard bench for rv_mem_port_arb: grants expected in priority order, checked at each ack.
`timescale 1ns/1ps
module tb_rv_mem_port_arb;
    import rv_mem_arb_pkg::*;

    localparam int unsigned XLEN = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              if_req_i;
    logic [XLEN-1:0]   if_adr_i;
    logic              if_ack_o;
    logic [XLEN-1:0]   if_q_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [XLEN-1:0]   dm_adr_i;
    logic [XLEN-1:0]   dm_d_i;
    logic [XLEN/8-1:0] dm_be_i;
    logic              dm_ack_o;
    logic [XLEN-1:0]   dm_q_o;
    logic              arb_owner_o;

    rv_mem_port_arb_if #(.XLEN(XLEN)) mem_bus ();

    rv_mem_port_arb #(
        .XLEN       (XLEN),
        .STARVE_MAX (4)
    ) u_dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .if_req_i    (if_req_i),
        .if_adr_i    (if_adr_i),
        .if_ack_o    (if_ack_o),
        .if_q_o      (if_q_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_adr_i    (dm_adr_i),
        .dm_d_i      (dm_d_i),
        .dm_be_i     (dm_be_i),
        .dm_ack_o    (dm_ack_o),
        .dm_q_o      (dm_q_o),
        .mem         (mem_bus),
        .arb_owner_o (arb_owner_o)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  be;
        logic [31:0] q;
    } exp_t;

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push_if(input logic [31:0] adr, input logic [31:0] q);
        exp_t e;
        e = '{owner: 1'b0, we: 1'b0, adr: adr, dat: 32'h0, be: 4'hF, q: q};
        sb.push_back(e);
    endtask

    task automatic push_dm(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] q);
        exp_t e;
        e = '{owner: 1'b1, we: we, adr: adr, dat: d, be: be, q: q};
        sb.push_back(e);
    endtask

    // Acts as the bus slave for one transaction: waits for the grant, checks it against
    // the scoreboard head, acks after 'delay' cycles and optionally drops the owner's req.
    task automatic serve(input int unsigned delay, input bit drop, output int unsigned waited);
        exp_t e;
        waited = 0;
        while (mem_bus.mem_req_o !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (mem_bus.mem_req_o !== 1'b1) begin
            check_eq("grant_timeout", 64'(mem_bus.mem_req_o), 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("owner", 64'(arb_owner_o), 64'(e.owner));
        check_eq("mem_we", 64'(mem_bus.mem_we_o), 64'(e.we));
        check_eq("mem_adr", 64'(mem_bus.mem_adr_o), 64'(e.adr));
        check_eq("mem_d", 64'(mem_bus.mem_d_o), 64'(e.dat));
        check_eq("mem_be", 64'(mem_bus.mem_be_o), 64'(e.be));
        for (int unsigned i = 0; i < delay; i++) begin
            step();
            check_eq("req_held", 64'(mem_bus.mem_req_o), 64'd1);
            check_eq("early_ack", 64'({if_ack_o, dm_ack_o}), 64'd0);
        end
        mem_bus.mem_ack_i = 1'b1;
        mem_bus.mem_q_i   = e.q;
        #1;
        if (e.owner) begin
            check_eq("dm_ack", 64'(dm_ack_o), 64'd1);
            check_eq("dm_q", 64'(dm_q_o), 64'(e.q));
            check_eq("if_ack_idle", 64'(if_ack_o), 64'd0);
            check_eq("if_q_idle", 64'(if_q_o), 64'd0);
            if (drop) dm_req_i = 1'b0;
        end else begin
            check_eq("if_ack", 64'(if_ack_o), 64'd1);
            check_eq("if_q", 64'(if_q_o), 64'(e.q));
            check_eq("dm_ack_idle", 64'(dm_ack_o), 64'd0);
            check_eq("dm_q_idle", 64'(dm_q_o), 64'd0);
            if (drop) if_req_i = 1'b0;
        end
        step();
        mem_bus.mem_ack_i = 1'b0;
        mem_bus.mem_q_i   = $urandom();
        #1;
        check_eq("idle_gap", 64'(mem_bus.mem_req_o), 64'd0);
        check_eq("ack_single", 64'({if_ack_o, dm_ack_o}), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, 64'(mem_bus.mem_req_o), 64'd0);
        check_eq({tag, "_we"}, 64'(mem_bus.mem_we_o), 64'd0);
        check_eq({tag, "_adr"}, 64'(mem_bus.mem_adr_o), 64'd0);
        check_eq({tag, "_d"}, 64'(mem_bus.mem_d_o), 64'd0);
        check_eq({tag, "_be"}, 64'(mem_bus.mem_be_o), 64'd0);
        check_eq({tag, "_owner"}, 64'(arb_owner_o), 64'd0);
        check_eq({tag, "_acks"}, 64'({if_ack_o, dm_ack_o}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;

        HRESETn           = 1'b0;
        if_req_i          = 1'b0;
        if_adr_i          = '0;
        dm_req_i          = 1'b0;
        dm_we_i           = 1'b0;
        dm_adr_i          = '0;
        dm_d_i            = '0;
        dm_be_i           = '0;
        mem_bus.mem_ack_i = 1'b0;
        mem_bus.mem_q_i   = '0;

        repeat (2) step();
        check_reset_outputs("rst");
        HRESETn = 1'b1;
        step();
        check_eq("post_rst_req", 64'(mem_bus.mem_req_o), 64'd0);

        // single fetch, ack two cycles after request rises
        if_adr_i = 32'h200;
        if_req_i = 1'b1;
        push_if(32'h200, 32'h0000_0013);
        serve(2, 1'b1, w);
        check_eq("if_latency", 64'(w), 64'd1);

        // simultaneous requests: data first, then fetch after one idle cycle
        dm_we_i  = 1'b1;
        dm_adr_i = 32'h1000;
        dm_d_i   = 32'hDEAD_BEEF;
        dm_be_i  = 4'hF;
        dm_req_i = 1'b1;
        if_adr_i = 32'h204;
        if_req_i = 1'b1;
        push_dm(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678);
        push_if(32'h204, 32'h0010_0093);
        serve(1, 1'b1, w);
        check_eq("dm_latency", 64'(w), 64'd1);
        serve(0, 1'b1, w);
        check_eq("if_after_gap", 64'(w), 64'd1);

        // both requests held continuously across six data-side grants
        dm_we_i  = 1'b0;
        dm_adr_i = 32'h2000;
        dm_d_i   = 32'h0;
        dm_be_i  = 4'hF;
        dm_req_i = 1'b1;
        if_adr_i = 32'h300;
        if_req_i = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) push_dm(1'b0, 32'h2000, 32'h0, 4'hF, 32'hA000 + 32'(i));
        push_if(32'h300, 32'hB000);
        push_dm(1'b0, 32'h2000, 32'h0, 4'hF, 32'hA004);
`else
        for (int i = 0; i < 6; i++) push_dm(1'b0, 32'h2000, 32'h0, 4'hF, 32'hA000 + 32'(i));
`endif
        for (int i = 0; i < 6; i++) begin
            serve(1, (i == 5), w);
        end
        push_if(32'h300, 32'hB001);
        serve(0, 1'b1, w);

        // stray ack in IDLE must be ignored
        step();
        mem_bus.mem_ack_i = 1'b1;
        mem_bus.mem_q_i   = 32'hFFFF_FFFF;
        #1;
        check_eq("stray_acks", 64'({if_ack_o, dm_ack_o}), 64'd0);
        check_eq("stray_qs", {if_q_o, dm_q_o}, 64'd0);
        step();
        mem_bus.mem_ack_i = 1'b0;
        #1;
        check_eq("stray_req", 64'(mem_bus.mem_req_o), 64'd0);
        if_adr_i = 32'h400;
        if_req_i = 1'b1;
        push_if(32'h400, 32'h0000_0067);
        serve(1, 1'b1, w);
        check_eq("stray_then_if", 64'(w), 64'd1);

        // requester drops req while busy: transaction still completes with an ack
        dm_we_i  = 1'b0;
        dm_adr_i = 32'h80;
        dm_d_i   = 32'h0BAD_F00D;
        dm_be_i  = 4'h3;
        dm_req_i = 1'b1;
        push_dm(1'b0, 32'h80, 32'h0BAD_F00D, 4'h3, 32'h0000_00C3);
        step();
        dm_req_i = 1'b0;
        serve(1, 1'b0, w);
        check_eq("viol_wait", 64'(w), 64'd0);

        // reset mid data transaction
        dm_we_i  = 1'b1;
        dm_adr_i = 32'h3000;
        dm_d_i   = 32'h55AA_55AA;
        dm_be_i  = 4'hC;
        dm_req_i = 1'b1;
        step();
        check_eq("pre_rst_req", 64'(mem_bus.mem_req_o), 64'd1);
        check_eq("pre_rst_adr", 64'(mem_bus.mem_adr_o), 64'h3000);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("arst");
        mem_bus.mem_ack_i = 1'b1;
        #1;
        check_eq("arst_ack", 64'(dm_ack_o), 64'd0);
        dm_req_i          = 1'b0;
        mem_bus.mem_ack_i = 1'b0;
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_arst_ack", 64'(dm_ack_o), 64'd0);
            check_eq("post_arst_req", 64'(mem_bus.mem_req_o), 64'd0);
        end

        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
